// File: rtl/brute_pkg.sv
// ============================================================================
// brute_pkg : shared state encoding and ASCII constants for the PIN sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package brute_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_PROMPT = 3'd2,
    ST_SEND        = 3'd3,
    ST_WAIT_RESP   = 3'd4,
    ST_NEXT        = 3'd5,
    ST_FOUND       = 3'd6,
    ST_EXHAUSTED   = 3'd7
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [3:0] BCD_NINE   = 4'd9;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_counter.sv
// ============================================================================
// bcd_counter : multi-digit BCD counter with ripple carry and all-nines flag
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_counter
  import brute_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] value,
  output logic                all_nines
);

  logic [4*DIGITS-1:0] value_next;
  logic                nines;
  logic                carry;
  logic [3:0]          d;

  always_comb begin
    value_next = value;
    nines      = 1'b1;
    carry      = 1'b1;
    d          = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = value[4*i +: 4];
      if (d != BCD_NINE) nines = 1'b0;
      if (carry) begin
        if (d == BCD_NINE) begin
          value_next[4*i +: 4] = 4'd0;
        end else begin
          value_next[4*i +: 4] = d + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  assign all_nines = nines;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= value_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/brute_sequencer.sv
// ============================================================================
// brute_sequencer : drives reset/prompt/send/classify loop of a PIN brute force
// Revision        : 1.0
// ============================================================================
`default_nettype none

module brute_sequencer
  import brute_pkg::*;
#(
  parameter int         CODE_LEN    = 4,
  parameter int         RST_CYCLES  = 16,
  parameter int         TIMEOUT     = 1000000,
  parameter logic [7:0] PROMPT_BYTE = 8'h3E,
  parameter logic [7:0] OK_BYTE     = 8'h4F,
  parameter logic [7:0] FAIL_BYTE   = 8'h58
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  target_rst_n,
  output logic                  busy,
  output logic                  found,
  output logic                  exhausted,
  output logic [4*CODE_LEN-1:0] code,
  output logic [31:0]           attempts
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int IW = $clog2(CODE_LEN + 1);

  state_t          state, state_next;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   rst_cnt;
  logic [IW-1:0]   send_idx;
  logic            code_clr, code_inc, code_all_nines;
  logic            idle_like, rst_done, timer_expired, prompt_seen, tx_fire, last_fire;

  // Byte idx of the transmit frame: digits MSD first, then LF.
  function automatic logic [7:0] send_byte(input logic [IW-1:0] idx,
                                           input logic [4*CODE_LEN-1:0] c);
    int pos;
    pos = 0;
    if (int'(idx) >= CODE_LEN) return ASCII_LF;
    pos = CODE_LEN - 1 - int'(idx);
    return digit_to_ascii(c[4*pos +: 4]);
  endfunction

  assign idle_like     = (state == ST_IDLE) || (state == ST_FOUND) || (state == ST_EXHAUSTED);
  assign rst_done      = (rst_cnt == RW'(RST_CYCLES - 1));
  assign timer_expired = (timer == TW'(TIMEOUT - 1));
  assign prompt_seen   = rx_valid && (rx_data == PROMPT_BYTE);
  assign tx_fire       = tx_valid && tx_ready;
  assign last_fire     = tx_fire && (send_idx == IW'(CODE_LEN));

  bcd_counter #(.DIGITS(CODE_LEN)) u_code (
    .clk       (clk),
    .rst       (rst),
    .clr       (code_clr),
    .inc       (code_inc),
    .value     (code),
    .all_nines (code_all_nines)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    code_clr   = 1'b0;
    code_inc   = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            state_next = ST_RESET;
            code_clr   = 1'b1;
          end
        end
        ST_RESET: begin
          if (rst_done) state_next = ST_WAIT_PROMPT;
        end
        ST_WAIT_PROMPT: begin
          if (prompt_seen)        state_next = ST_SEND;
          else if (timer_expired) state_next = ST_RESET;
        end
        ST_SEND: begin
          if (last_fire) state_next = ST_WAIT_RESP;
        end
        ST_WAIT_RESP: begin
          if (rx_valid && rx_data == OK_BYTE)        state_next = ST_FOUND;
          else if (rx_valid && rx_data == FAIL_BYTE) state_next = ST_NEXT;
          else if (timer_expired)                    state_next = ST_NEXT;
        end
        ST_NEXT: begin
          if (code_all_nines) begin
            state_next = ST_EXHAUSTED;
          end else begin
            state_next = ST_RESET;
            code_inc   = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Timer and reset counter restart whenever the state changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer    <= '0;
      rst_cnt  <= '0;
      send_idx <= '0;
      attempts <= '0;
    end else begin
      if (state_next == state && (state == ST_WAIT_PROMPT || state == ST_WAIT_RESP))
        timer <= timer + TW'(1);
      else
        timer <= '0;

      if (state == ST_RESET && state_next == ST_RESET) rst_cnt <= rst_cnt + RW'(1);
      else                                             rst_cnt <= '0;

      if (state != ST_SEND)                              send_idx <= '0;
      else if (tx_fire && send_idx != IW'(CODE_LEN))     send_idx <= send_idx + IW'(1);

      if (!abort) begin
        if (idle_like && start)  attempts <= '0;
        else if (state == ST_NEXT) attempts <= attempts + 32'd1;
      end
    end
  end

  // First SEND cycle loads byte 0; each handshake loads the following byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (abort || state != ST_SEND) begin
      tx_valid <= 1'b0;
    end else if (!tx_valid) begin
      tx_valid <= 1'b1;
      tx_data  <= send_byte(send_idx, code);
    end else if (tx_fire) begin
      if (last_fire) tx_valid <= 1'b0;
      else           tx_data  <= send_byte(send_idx + IW'(1), code);
    end
  end

  assign target_rst_n = (state != ST_RESET);
  assign busy         = !idle_like;
  assign found        = (state == ST_FOUND);
  assign exhausted    = (state == ST_EXHAUSTED);

endmodule

`default_nettype wire
